// File: rtl/systolic_array_tile_controller.sv
// Tile sequencer for an output-stationary systolic array.
// Fetches K operand vectors, skews the valids, flushes, then drains results.
module systolic_array_tile_controller #(
    parameter int NUM_ROW              = 8,
    parameter int NUM_COL              = 8,
    parameter int LOG2_SRAM_BANK_DEPTH = 10,
    parameter int K_WIDTH              = 10,
    parameter int SKEW_TOP_INPUT_EN    = 1,
    parameter int SKEW_LEFT_INPUT_EN   = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_start,
    input  logic [K_WIDTH-1:0]              i_k_len,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_rd_start_addr,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_rd_start_addr,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_down_wr_start_addr,
    input  logic                            i_host_top_wr_en,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_host_top_wr_addr,
    input  logic                            i_host_left_wr_en,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_host_left_wr_addr,
    input  logic                            i_host_down_rd_en,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_host_down_rd_addr,
    output logic                            o_top_sram_en,
    output logic                            o_top_sram_we,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_addr,
    output logic                            o_left_sram_en,
    output logic                            o_left_sram_we,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_addr,
    output logic [NUM_COL-1:0]              o_down_sram_en,
    output logic                            o_down_sram_we,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_addr,
    output logic [NUM_COL-1:0]              o_valid_top,
    output logic [NUM_ROW-1:0]              o_valid_left,
    output logic                            o_drain,
    input  logic [NUM_COL-1:0]              i_sa_valid_down,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_cfg_err,
    output logic [2:0]                      o_state
);

    localparam int AW = LOG2_SRAM_BANK_DEPTH;
    localparam int FLUSH_LEN = 1 + SKEW_TOP_INPUT_EN * (NUM_COL - 1)
                             + SKEW_LEFT_INPUT_EN * (NUM_ROW - 1)
                             + (NUM_ROW - 1) + (NUM_COL - 1);
    localparam int FW = $clog2(FLUSH_LEN + 1);
    localparam int CW = (K_WIDTH > FW) ? K_WIDTH : FW;
    localparam int PW = (NUM_ROW > NUM_COL) ? NUM_ROW : NUM_COL;
    localparam int RW = $clog2(NUM_ROW + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_FLUSH = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [K_WIDTH-1:0] k_q;
    logic [AW-1:0]  top_addr_q;
    logic [AW-1:0]  left_addr_q;
    logic [AW-1:0]  down_addr_q;
    logic [RW-1:0]  rows;
    logic [PW-1:0]  vpipe;

    // vpipe[0] is the read-latency-aligned valid; bit i is that delayed i cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            k_q         <= '0;
            top_addr_q  <= '0;
            left_addr_q <= '0;
            down_addr_q <= '0;
            rows        <= '0;
            vpipe       <= '0;
            o_drain     <= 1'b0;
            o_done      <= 1'b0;
            o_cfg_err   <= 1'b0;
        end else begin
            vpipe     <= (vpipe << 1) | PW'(state == S_FETCH);
            o_drain   <= 1'b0;
            o_done    <= 1'b0;
            o_cfg_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_k_len == '0) begin
                            o_cfg_err <= 1'b1;
                        end else begin
                            k_q         <= i_k_len;
                            top_addr_q  <= i_top_rd_start_addr;
                            left_addr_q <= i_left_rd_start_addr;
                            down_addr_q <= i_down_wr_start_addr;
                            cnt         <= '0;
                            state       <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    top_addr_q  <= top_addr_q + 1'b1;
                    left_addr_q <= left_addr_q + 1'b1;
                    cnt         <= cnt + 1'b1;
                    if (cnt == CW'(k_q) - CW'(1)) begin
                        cnt   <= '0;
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(FLUSH_LEN - 1)) begin
                        cnt     <= '0;
                        rows    <= '0;
                        o_drain <= 1'b1;
                        state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (|i_sa_valid_down) begin
                        down_addr_q <= down_addr_q + 1'b1;
                        rows        <= rows + 1'b1;
                        if (rows == RW'(NUM_ROW - 1)) begin
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_top_sram_en    = 1'b0;
        o_top_sram_we    = 1'b0;
        o_top_sram_addr  = '0;
        o_left_sram_en   = 1'b0;
        o_left_sram_we   = 1'b0;
        o_left_sram_addr = '0;
        o_down_sram_en   = '0;
        o_down_sram_we   = 1'b0;
        o_down_sram_addr = '0;
        unique case (state)
            S_IDLE: begin
                o_top_sram_en    = i_host_top_wr_en;
                o_top_sram_we    = i_host_top_wr_en;
                o_top_sram_addr  = i_host_top_wr_addr;
                o_left_sram_en   = i_host_left_wr_en;
                o_left_sram_we   = i_host_left_wr_en;
                o_left_sram_addr = i_host_left_wr_addr;
                o_down_sram_en   = {NUM_COL{i_host_down_rd_en}};
                o_down_sram_addr = i_host_down_rd_addr;
            end
            S_FETCH: begin
                o_top_sram_en    = 1'b1;
                o_top_sram_addr  = top_addr_q;
                o_left_sram_en   = 1'b1;
                o_left_sram_addr = left_addr_q;
            end
            S_DRAIN: begin
                o_down_sram_en   = i_sa_valid_down;
                o_down_sram_we   = |i_sa_valid_down;
                o_down_sram_addr = down_addr_q;
            end
            default: ;
        endcase
    end

    for (genvar c = 0; c < NUM_COL; c++) begin : g_vtop
        assign o_valid_top[c] = (SKEW_TOP_INPUT_EN != 0) ? vpipe[c] : vpipe[0];
    end
    for (genvar r = 0; r < NUM_ROW; r++) begin : g_vleft
        assign o_valid_left[r] = (SKEW_LEFT_INPUT_EN != 0) ? vpipe[r] : vpipe[0];
    end

    assign o_busy  = (state != S_IDLE);
    assign o_state = state;

endmodule

// File: tb/tb_systolic_array_tile_controller.sv
// Bench for the tile controller: timeline model of one tile per start,
// directed cases from the test plan plus randomized traffic.
module tb_systolic_array_tile_controller;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int AW = 10;
    localparam int KW = 10;
    localparam int ST = 1;
    localparam int SL = 1;
    localparam int FL = 1 + ST * (NC - 1) + SL * (NR - 1) + (NR - 1) + (NC - 1);
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_start = 1'b0;
    logic [KW-1:0] i_k_len = '0;
    logic [AW-1:0] i_top_rd_start_addr = '0;
    logic [AW-1:0] i_left_rd_start_addr = '0;
    logic [AW-1:0] i_down_wr_start_addr = '0;
    logic i_host_top_wr_en = 1'b0;
    logic [AW-1:0] i_host_top_wr_addr = '0;
    logic i_host_left_wr_en = 1'b0;
    logic [AW-1:0] i_host_left_wr_addr = '0;
    logic i_host_down_rd_en = 1'b0;
    logic [AW-1:0] i_host_down_rd_addr = '0;
    logic [NC-1:0] i_sa_valid_down = '0;
    logic o_top_sram_en, o_top_sram_we;
    logic [AW-1:0] o_top_sram_addr;
    logic o_left_sram_en, o_left_sram_we;
    logic [AW-1:0] o_left_sram_addr;
    logic [NC-1:0] o_down_sram_en;
    logic o_down_sram_we;
    logic [AW-1:0] o_down_sram_addr;
    logic [NC-1:0] o_valid_top;
    logic [NR-1:0] o_valid_left;
    logic o_drain, o_busy, o_done, o_cfg_err;
    logic [2:0] o_state;

    systolic_array_tile_controller #(
        .NUM_ROW(NR), .NUM_COL(NC), .LOG2_SRAM_BANK_DEPTH(AW),
        .K_WIDTH(KW), .SKEW_TOP_INPUT_EN(ST), .SKEW_LEFT_INPUT_EN(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_k_len(i_k_len),
        .i_top_rd_start_addr(i_top_rd_start_addr),
        .i_left_rd_start_addr(i_left_rd_start_addr),
        .i_down_wr_start_addr(i_down_wr_start_addr),
        .i_host_top_wr_en(i_host_top_wr_en),
        .i_host_top_wr_addr(i_host_top_wr_addr),
        .i_host_left_wr_en(i_host_left_wr_en),
        .i_host_left_wr_addr(i_host_left_wr_addr),
        .i_host_down_rd_en(i_host_down_rd_en),
        .i_host_down_rd_addr(i_host_down_rd_addr),
        .o_top_sram_en(o_top_sram_en), .o_top_sram_we(o_top_sram_we),
        .o_top_sram_addr(o_top_sram_addr),
        .o_left_sram_en(o_left_sram_en), .o_left_sram_we(o_left_sram_we),
        .o_left_sram_addr(o_left_sram_addr),
        .o_down_sram_en(o_down_sram_en), .o_down_sram_we(o_down_sram_we),
        .o_down_sram_addr(o_down_sram_addr),
        .o_valid_top(o_valid_top), .o_valid_left(o_valid_left),
        .o_drain(o_drain), .i_sa_valid_down(i_sa_valid_down),
        .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err),
        .o_state(o_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    // Model of the tile in flight: n counts cycles since start was taken
    bit m_busy = 0;
    bit m_err = 0;
    int m_n, m_k, m_ts, m_ls, m_ds, m_rows;
    int pin_id = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit in_fetch();
        return m_busy && m_n <= m_k;
    endfunction
    function automatic bit in_flush();
        return m_busy && m_n > m_k && m_n <= m_k + FL;
    endfunction
    function automatic bit in_drain();
        return m_busy && m_n > m_k + FL && m_rows < NR;
    endfunction
    function automatic bit in_done();
        return m_busy && m_n > m_k + FL && m_rows == NR;
    endfunction

    task automatic pin_checks();
        if (pin_id == 1 && m_busy) begin
            if (m_n == 1) begin
                chk("pinA top addr n1", int'(o_top_sram_addr), 10);
                chk("pinA left addr n1", int'(o_left_sram_addr), 20);
            end
            if (m_n == 3) begin
                chk("pinA top addr n3", int'(o_top_sram_addr), 12);
                chk("pinA left addr n3", int'(o_left_sram_addr), 22);
            end
            if (m_n == 2) chk("pinA vtop0 n2", int'(o_valid_top[0]), 1);
            if (m_n == 4) chk("pinA vtop0 n4", int'(o_valid_top[0]), 1);
            if (m_n == 5) begin
                chk("pinA vtop0 n5", int'(o_valid_top[0]), 0);
                chk("pinA vtop3 n5", int'(o_valid_top[3]), 1);
            end
            if (m_n == 7) chk("pinA vtop3 n7", int'(o_valid_top[3]), 1);
            if (m_n == 8) chk("pinA vtop3 n8", int'(o_valid_top[3]), 0);
            if (m_n == 16) chk("pinA drain n16", int'(o_drain), 0);
            if (m_n == 17) begin
                chk("pinA drain n17", int'(o_drain), 1);
                chk("pinA down addr n17", int'(o_down_sram_addr), 100);
            end
            if (m_n == 20) chk("pinA down addr n20", int'(o_down_sram_addr), 103);
            if (m_n == 21) begin
                chk("pinA done n21", int'(o_done), 1);
                chk("pinA state n21", int'(o_state), 4);
            end
        end
        if (pin_id == 2 && m_busy) begin
            if (m_n == 2) begin
                chk("pinB top addr n2", int'(o_top_sram_addr), 1023);
                chk("pinB host we ignored", int'(o_top_sram_we), 0);
            end
            if (m_n == 3) chk("pinB top addr n3", int'(o_top_sram_addr), 0);
            if (m_n == 4) chk("pinB top addr n4", int'(o_top_sram_addr), 1);
        end
    endtask

    // Compare outputs for the current cycle, then advance the model past the next edge
    task automatic step();
        int es, ta, la, da;
        bit te, le, dwe;
        logic [NC-1:0] den, vt;
        logic [NR-1:0] vl;
        bit nerr;
        #1;
        es = 0; te = 0; le = 0; ta = 0; la = 0; da = 0; dwe = 0; den = '0;
        if (!m_busy) begin
            te = i_host_top_wr_en; ta = int'(i_host_top_wr_addr);
            le = i_host_left_wr_en; la = int'(i_host_left_wr_addr);
            den = {NC{i_host_down_rd_en}}; da = int'(i_host_down_rd_addr);
        end else if (in_fetch()) begin
            es = 1; te = 1; le = 1;
            ta = (m_ts + m_n - 1) % DEPTH;
            la = (m_ls + m_n - 1) % DEPTH;
        end else if (in_flush()) begin
            es = 2;
        end else if (in_drain()) begin
            es = 3; den = i_sa_valid_down; dwe = |i_sa_valid_down;
            da = (m_ds + m_rows) % DEPTH;
        end else begin
            es = 4;
        end
        for (int c = 0; c < NC; c++)
            vt[c] = m_busy && m_n >= 2 + c * ST && m_n <= m_k + 1 + c * ST;
        for (int r = 0; r < NR; r++)
            vl[r] = m_busy && m_n >= 2 + r * SL && m_n <= m_k + 1 + r * SL;
        chk("state", int'(o_state), es);
        chk("busy", int'(o_busy), int'(es != 0));
        chk("top en", int'(o_top_sram_en), int'(te));
        chk("top we", int'(o_top_sram_we), int'(te && !m_busy));
        if (te) chk("top addr", int'(o_top_sram_addr), ta);
        chk("left en", int'(o_left_sram_en), int'(le));
        chk("left we", int'(o_left_sram_we), int'(le && !m_busy));
        if (le) chk("left addr", int'(o_left_sram_addr), la);
        chk("down en", int'(o_down_sram_en), int'(den));
        chk("down we", int'(o_down_sram_we), int'(dwe));
        if (den != 0) chk("down addr", int'(o_down_sram_addr), da);
        chk("valid top", int'(o_valid_top), int'(vt));
        chk("valid left", int'(o_valid_left), int'(vl));
        chk("drain", int'(o_drain), int'(m_busy && m_n == m_k + FL + 1));
        chk("done", int'(o_done), int'(in_done()));
        chk("cfg err", int'(o_cfg_err), int'(m_err));
        pin_checks();
        nerr = 0;
        if (rst_n) begin
            if (!m_busy) begin
                if (i_start) begin
                    if (i_k_len == 0) nerr = 1;
                    else begin
                        m_busy = 1; m_n = 1; m_k = int'(i_k_len); m_rows = 0;
                        m_ts = int'(i_top_rd_start_addr);
                        m_ls = int'(i_left_rd_start_addr);
                        m_ds = int'(i_down_wr_start_addr);
                    end
                end
            end else if (in_done()) begin
                m_busy = 0;
            end else begin
                if (in_drain() && |i_sa_valid_down) m_rows++;
                m_n++;
            end
        end
        m_err = nerr;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_start = 0; i_k_len = '0;
        i_host_top_wr_en = 0; i_host_top_wr_addr = '0;
        i_host_left_wr_en = 0; i_host_left_wr_addr = '0;
        i_host_down_rd_en = 0; i_host_down_rd_addr = '0;
        i_sa_valid_down = '0;
    endtask

    task automatic run_tile(input int k, input int ts, input int ls, input int ds,
                            input bit host_on);
        int cyc;
        i_k_len = KW'(k);
        i_top_rd_start_addr = AW'(ts);
        i_left_rd_start_addr = AW'(ls);
        i_down_wr_start_addr = AW'(ds);
        i_start = 1;
        step();
        i_start = 0;
        cyc = 0;
        while (m_busy && cyc < 200) begin
            i_host_top_wr_en = host_on; i_host_top_wr_addr = 5;
            i_sa_valid_down = in_drain() ? {NC{1'b1}} : '0;
            step();
            cyc++;
        end
        chk("tile finished in bound", int'(m_busy), 0);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        @(negedge clk); #1;
        step();
        step();
        rst_n = 1;
        step();

        pin_id = 1;
        run_tile(3, 10, 20, 100, 0);
        step();
        chk("pinA back to idle", int'(o_state), 0);

        pin_id = 2;
        run_tile(4, 1022, 7, 1021, 1);
        pin_id = 0;

        i_host_top_wr_en = 1; i_host_top_wr_addr = 5;
        #1;
        chk("idle host top en", int'(o_top_sram_en), 1);
        chk("idle host top we", int'(o_top_sram_we), 1);
        chk("idle host top addr", int'(o_top_sram_addr), 5);
        step();
        clear_inputs();

        i_start = 1; i_k_len = 0;
        step();
        i_start = 0;
        #1;
        chk("k0 cfg err", int'(o_cfg_err), 1);
        chk("k0 state", int'(o_state), 0);
        chk("k0 top en", int'(o_top_sram_en), 0);
        step();

        i_k_len = 5; i_top_rd_start_addr = 3; i_start = 1;
        step();
        i_start = 0;
        step();
        rst_n = 0;
        m_busy = 0; m_err = 0;
        #1;
        chk("rst state", int'(o_state), 0);
        chk("rst top en", int'(o_top_sram_en), 0);
        chk("rst valid top", int'(o_valid_top), 0);
        step();
        step();
        rst_n = 1;
        step();
        run_tile(2, 500, 600, 700, 0);

        for (int i = 0; i < 3000; i++) begin
            i_host_top_wr_en = 1'($urandom);
            i_host_top_wr_addr = AW'($urandom);
            i_host_left_wr_en = 1'($urandom);
            i_host_left_wr_addr = AW'($urandom);
            i_host_down_rd_en = 1'($urandom);
            i_host_down_rd_addr = AW'($urandom);
            i_sa_valid_down = ($urandom_range(0, 2) == 0) ? '0 : NC'($urandom);
            i_start = ($urandom_range(0, 7) == 0);
            i_k_len = ($urandom_range(0, 9) == 0) ? '0 : KW'($urandom_range(1, 12));
            i_top_rd_start_addr = AW'($urandom);
            i_left_rd_start_addr = AW'($urandom);
            i_down_wr_start_addr = AW'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/systolic_array_tile_controller.md
Name: systolic_array_tile_controller

Overview:
- Self-sequencing controller for an NUM_ROW x NUM_COL output-stationary systolic array.
- Owns its own FSM; a single start/done handshake runs one output tile: fetch K operand vectors from top/left SRAM banks, generate skewed valids, flush, drain results to the down SRAM.
- Replaces the externally-stated controller generation. Adds run-time K length, address wrap, a skew generator, a drain handshake and host-port arbitration.

Parameters:
- NUM_ROW, 8, array rows (left SRAM vector lanes).
- NUM_COL, 8, array columns (top SRAM vector lanes).
- LOG2_SRAM_BANK_DEPTH, 10, SRAM address width; all addresses wrap modulo 2^LOG2_SRAM_BANK_DEPTH.
- K_WIDTH, 10, width of the reduction-length field.
- SKEW_TOP_INPUT_EN, 1, 1 = column c valid delayed c cycles.
- SKEW_LEFT_INPUT_EN, 1, 1 = row r valid delayed r cycles.

Ports:
- clk, in, 1, clock
- rst_n, in, 1, asynchronous active-low reset
- i_start, in, 1, start pulse (accepted only in IDLE)
- i_k_len, in, K_WIDTH, reduction length K, sampled at start
- i_top_rd_start_addr, in, LOG2, top bank first read address, sampled at start
- i_left_rd_start_addr, in, LOG2, left bank first read address, sampled at start
- i_down_wr_start_addr, in, LOG2, first result row address, sampled at start
- i_host_top_wr_en, in, 1, host top write
- i_host_top_wr_addr, in, LOG2, host top write address
- i_host_left_wr_en, in, 1, host left write
- i_host_left_wr_addr, in, LOG2, host left write address
- i_host_down_rd_en, in, 1, host down read
- i_host_down_rd_addr, in, LOG2, host down read address
- o_top_sram_en, out, 1, top bank enable
- o_top_sram_we, out, 1, top bank write enable
- o_top_sram_addr, out, LOG2, top bank address
- o_left_sram_en, out, 1, left bank enable
- o_left_sram_we, out, 1, left bank write enable
- o_left_sram_addr, out, LOG2, left bank address
- o_down_sram_en, out, NUM_COL, down bank per-column enable
- o_down_sram_we, out, 1, down bank write enable
- o_down_sram_addr, out, LOG2, down bank address
- o_valid_top, out, NUM_COL, per-column operand valid
- o_valid_left, out, NUM_ROW, per-row operand valid
- o_drain, out, 1, one-cycle pulse telling the datapath to shift accumulators out
- i_sa_valid_down, in, NUM_COL, datapath result valid per column
- o_busy, out, 1, state != IDLE
- o_done, out, 1, one-cycle completion pulse
- o_cfg_err, out, 1, one-cycle pulse: start rejected
- o_state, out, 3, current FSM state

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all registered outputs 0; counters 0. Reset mid-run abandons the tile; no done pulse is issued.
- States: IDLE=0, FETCH=1, FLUSH=2, DRAIN=3, DONE=4.
- IDLE:
  - Host ports pass through combinationally: top/left en=we=host_wr_en, addr=host addr; down en={NUM_COL{host_rd_en}}, we=0.
  - i_start with i_k_len!=0 → latch config, go to FETCH next cycle.
  - i_start with K=0 → stay IDLE, o_cfg_err=1 for one cycle.
- FETCH: exactly K cycles.
  - Cycle k: top/left en=1, we=0, addr=start+k (wraps).
  - After cycle K-1 → FLUSH.
  - Host writes are ignored while busy.
- Valid generation:
  - base_valid = read issued one cycle earlier (SRAM read latency 1).
  - o_valid_top[c] = base_valid delayed c cycles if SKEW_TOP_INPUT_EN, else base_valid. o_valid_left[r] likewise.
  - Each bit is high for exactly K cycles per tile.
- FLUSH:
  - Wait FLUSH_LEN = 1 + SKEW_TOP_INPUT_EN*(NUM_COL-1) + SKEW_LEFT_INPUT_EN*(NUM_ROW-1) + (NUM_ROW-1) + (NUM_COL-1) cycles.
  - Then o_drain=1 for one cycle, go to DRAIN.
- DRAIN:
  - Each cycle with |i_sa_valid_down: o_down_sram_en=i_sa_valid_down, we=1, addr=down_start+rows_written; rows_written++.
  - When rows_written reaches NUM_ROW → DONE.
  - Cycles with no valid: en=0, no increment.
- DONE: o_done=1 for one cycle, → IDLE. The next start is accepted in the following IDLE cycle.
- i_start while busy: ignored, no error.
- Addresses wrap silently: start+k and down_start+row, modulo 2^LOG2_SRAM_BANK_DEPTH.
- o_busy is 1 in states 1–4.

Test Plan:
- NUM_ROW=NUM_COL=4, K=3, top_start=10, left_start=20 → top addr 10,11,12 and left addr 20,21,22 on 3 consecutive cycles.
  - o_valid_top[0] high cycles 2–4; o_valid_top[3] high cycles 5–7.
  - FLUSH=13 cycles, then o_drain pulse.
- DRAIN with i_sa_valid_down=4'hF for 4 cycles, down_start=100 → writes at 100..103, then o_done pulse; o_state returns to 0.
- top_start=1022, K=4, LOG2=10 → top addresses 1022,1023,0,1.
- i_start with K=0 → o_cfg_err pulse, o_state stays 0, no SRAM enables.
- Host write to top addr 5 during FETCH ignored; during IDLE it appears on o_top_sram_* the same cycle.
- rst_n low during FETCH cycle 2 → all outputs 0 immediately, state IDLE, no o_done; a fresh start then runs normally.
